rgb_fade_engine: RTL and testbench

- Parametrised multi-channel PWM fade generator; successor to the fixed 3-channel RGB hue fader in the top-level LED design.
- Generalises channel count, PWM period and ramp rate.
- Adds run-time mode select: hue wheel, breathe, static and off.
- Drives active-low LED pins directly from top, one output per channel.

---
 rtl/fade_pkg.sv | 32 +++
 rtl/pwm_compare.sv | 22 ++
 rtl/rgb_fade_engine.sv | 141 ++++++++++++++
 tb/tb_rgb_fade_engine.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fade_pkg.sv
// Shared types and helpers for the multi-channel PWM fade engine.
// Holds the run mode, ramp direction and the six-step hue waveform.
package fade_pkg;

  typedef enum logic [1:0] {
    MODE_HUE     = 2'd0,
    MODE_BREATHE = 2'd1,
    MODE_STATIC  = 2'd2,
    MODE_OFF     = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int HUE_PHASES = 6;

  // One channel's duty at hue step q: full, ramp down, off, off, ramp up, full.
  function automatic int unsigned hue_wave(input logic [2:0] q,
                                           input int unsigned ramp,
                                           input int unsigned interval);
    case (q)
      3'd0:       return interval;
      3'd1:       return interval - ramp;
      3'd2, 3'd3: return 0;
      3'd4:       return ramp;
      default:    return interval;
    endcase
  endfunction

endpackage

// File: rtl/pwm_compare.sv
// Per-channel PWM output stage: registered compare of the shared period
// counter against the channel duty, gated by enable, driving an active-low pin.
module pwm_compare #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [W-1:0] cnt,
  input  logic [W-1:0] duty,
  output logic         pwm_n
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_n <= 1'b1;
    end else begin
      pwm_n <= ~(enable && (cnt < duty));
    end
  end

endmodule

// File: rtl/rgb_fade_engine.sv
// Multi-channel PWM fade generator: free-running period counter, ramp/phase
// sequencer updated once per period, and one pwm_compare stage per channel.
//
// state (mode_q, dir_q) | meaning
// MODE_HUE,     DIR_UP  | ramp climbs to full, then resets and hue_phase steps
// MODE_BREATHE, DIR_UP  | ramp climbs, holds one period at full, then turns
// MODE_BREATHE, DIR_DOWN| ramp falls, holds one period at zero, then turns
// MODE_STATIC,  -       | duties from static_duty, ramp held
// MODE_OFF,     -       | all duties zero, ramp held
module rgb_fade_engine
  import fade_pkg::*;
#(
  parameter  int NUM_CH       = 3,
  parameter  int PWM_INTERVAL = 1200,
  parameter  int DUTY_INC     = 4,
  localparam int DUTY_W       = $clog2(PWM_INTERVAL + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [1:0]               mode,
  input  logic [NUM_CH*DUTY_W-1:0] static_duty,
  output logic [NUM_CH-1:0]        pwm_out_n,
  output logic                     period_tick,
  output logic [2:0]               hue_phase
);

  localparam logic [DUTY_W-1:0] FULL  = DUTY_W'(PWM_INTERVAL);
  localparam logic [DUTY_W-1:0] LAST  = DUTY_W'(PWM_INTERVAL - 1);
  localparam logic [DUTY_W:0]   INC_E = (DUTY_W + 1)'(DUTY_INC);

  logic [DUTY_W-1:0] cnt;
  logic              period_end;

  mode_e             mode_q, mode_nxt, mode_in;
  dir_e              dir_q, dir_nxt;
  logic [DUTY_W-1:0] ramp_q, ramp_nxt, ramp_up, ramp_dn;
  logic [DUTY_W:0]   ramp_sum;
  logic [2:0]        phase_q, phase_nxt;

  logic [NUM_CH-1:0][DUTY_W-1:0] duty_q, duty_nxt;

  assign period_end = (cnt == LAST);
  assign mode_in    = mode_e'(mode);
  assign hue_phase  = phase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      period_tick <= 1'b0;
    end else begin
      cnt         <= period_end ? '0 : cnt + DUTY_W'(1);
      period_tick <= period_end;
    end
  end

  // Saturating ramp steps; one extra bit keeps the add from wrapping.
  assign ramp_sum = {1'b0, ramp_q} + INC_E;
  assign ramp_up  = (ramp_sum > {1'b0, FULL}) ? FULL : ramp_sum[DUTY_W-1:0];
  assign ramp_dn  = ({1'b0, ramp_q} > INC_E) ? (ramp_q - INC_E[DUTY_W-1:0]) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_OFF;
      dir_q   <= DIR_UP;
      ramp_q  <= '0;
      phase_q <= '0;
      duty_q  <= '0;
    end else if (period_end) begin
      mode_q  <= mode_nxt;
      dir_q   <= dir_nxt;
      ramp_q  <= ramp_nxt;
      phase_q <= phase_nxt;
      duty_q  <= duty_nxt;
    end
  end

  always_comb begin
    mode_nxt  = mode_q;
    dir_nxt   = dir_q;
    ramp_nxt  = ramp_q;
    phase_nxt = phase_q;
    if (mode_in != mode_q) begin
      mode_nxt  = mode_in;
      dir_nxt   = DIR_UP;
      ramp_nxt  = '0;
      phase_nxt = '0;
    end else if (enable) begin
      case (mode_q)
        MODE_HUE: begin
          if (ramp_q == FULL) begin
            ramp_nxt  = '0;
            phase_nxt = (phase_q == 3'(HUE_PHASES - 1)) ? 3'd0 : phase_q + 3'd1;
          end else begin
            ramp_nxt = ramp_up;
          end
        end
        MODE_BREATHE: begin
          // Reaching an endpoint only flips direction, so the endpoint shows for one period.
          if (dir_q == DIR_UP) begin
            if (ramp_q == FULL) dir_nxt = DIR_DOWN;
            else                ramp_nxt = ramp_up;
          end else begin
            if (ramp_q == '0)   dir_nxt = DIR_UP;
            else                ramp_nxt = ramp_dn;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int OFS = 2 * (c % 3);

    logic [2:0]        q;
    logic [DUTY_W-1:0] hue_duty;
    logic [DUTY_W-1:0] stat_raw;
    logic [DUTY_W-1:0] stat_duty;

    assign q         = (phase_nxt >= 3'(OFS)) ? (phase_nxt - 3'(OFS))
                                              : (phase_nxt + 3'(HUE_PHASES - OFS));
    assign hue_duty  = DUTY_W'(hue_wave(q, 32'(ramp_nxt), 32'(PWM_INTERVAL)));
    assign stat_raw  = static_duty[c*DUTY_W +: DUTY_W];
    assign stat_duty = (stat_raw > FULL) ? FULL : stat_raw;

    assign duty_nxt[c] = (mode_nxt == MODE_HUE)     ? hue_duty  :
                         (mode_nxt == MODE_BREATHE) ? ramp_nxt  :
                         (mode_nxt == MODE_STATIC)  ? stat_duty : '0;

    pwm_compare #(.W(DUTY_W)) u_pwm (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (enable),
      .cnt    (cnt),
      .duty   (duty_q[c]),
      .pwm_n  (pwm_out_n[c])
    );
  end

endmodule

// File: tb/tb_rgb_fade_engine.sv
// Directed bench for rgb_fade_engine with an 8-clock period and ramp step 2.
// Table rows: inputs driven at a period start take effect in the next row's period.
module tb_rgb_fade_engine;

  localparam int NUM_CH = 3;
  localparam int PI     = 8;
  localparam int INC    = 2;
  localparam int DW     = 4;

  localparam logic [1:0] M_HUE = 2'd0, M_BR = 2'd1, M_ST = 2'd2, M_OFF = 2'd3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 enable;
  logic [1:0]           mode;
  logic [NUM_CH*DW-1:0] static_duty;
  logic [NUM_CH-1:0]    pwm_out_n;
  logic                 period_tick;
  logic [2:0]           hue_phase;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rgb_fade_engine #(
    .NUM_CH       (NUM_CH),
    .PWM_INTERVAL (PI),
    .DUTY_INC     (INC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .mode        (mode),
    .static_duty (static_duty),
    .pwm_out_n   (pwm_out_n),
    .period_tick (period_tick),
    .hue_phase   (hue_phase)
  );

  typedef struct {
    logic [1:0]  m;
    logic [11:0] sd;
    int          lo0, lo1, lo2;
    int          ph;
  } row_t;

  row_t tbl[$];

  task automatic add(input logic [1:0] m, input logic [11:0] sd,
                     input int lo0, input int lo1, input int lo2, input int ph);
    row_t r;
    r.m = m; r.sd = sd; r.lo0 = lo0; r.lo1 = lo1; r.lo2 = lo2; r.ph = ph;
    tbl.push_back(r);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] m, input logic [11:0] sd, input logic en);
    mode        = m;
    static_duty = sd;
    enable      = en;
  endtask

  // Starts at the negedge of a period_tick cycle; samples the 8 output cycles of
  // that period and ends on the next period_tick cycle.
  task automatic run_period(input int chg_at, input logic [1:0] m, input logic [11:0] sd,
                            input logic en, output int l0, output int l1, output int l2,
                            output int ph, output int tick_bad);
    l0 = 0; l1 = 0; l2 = 0; tick_bad = 0;
    ph = int'(hue_phase);
    if (chg_at == 0) drive(m, sd, en);
    for (int k = 1; k <= PI; k++) begin
      @(negedge clk);
      if (!pwm_out_n[0]) l0++;
      if (!pwm_out_n[1]) l1++;
      if (!pwm_out_n[2]) l2++;
      if (period_tick != (k == PI)) tick_bad++;
      if (k == chg_at) drive(m, sd, en);
    end
  endtask

  task automatic period_chk(input string name, input logic [1:0] m, input logic [11:0] sd,
                            input logic en, input int chg_at,
                            input int e0, input int e1, input int e2, input int eph);
    int l0, l1, l2, ph, tb;
    run_period(chg_at, m, sd, en, l0, l1, l2, ph, tb);
    check({name, "_ch0"}, l0, e0);
    check({name, "_ch1"}, l1, e1);
    check({name, "_ch2"}, l2, e2);
    check({name, "_phase"}, ph, eph);
    check({name, "_tick"}, tb, 0);
  endtask

  task automatic wait_tick(input int limit, output int waited);
    waited = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (period_tick) begin
        waited = i;
        return;
      end
    end
  endtask

  initial begin
    int w, l0, l1, l2, ph, tb;

    rst_n = 1'b0;
    drive(M_OFF, 12'h000, 1'b1);
    repeat (3) @(negedge clk);
    check("rst_pwm", int'(pwm_out_n), 7);
    check("rst_tick", int'(period_tick), 0);
    check("rst_phase", int'(hue_phase), 0);
    rst_n = 1'b1;
    wait_tick(20, w);
    check("first_tick_delay", w, PI);

    // OFF, then STATIC {8,3,0}, then STATIC clamp of 15
    for (int i = 0; i < 4; i++) add(M_OFF, 12'h000, 0, 0, 0, 0);
    add(M_ST, 12'h830, 0, 0, 0, 0);
    add(M_ST, 12'h830, 0, 3, 8, 0);
    add(M_ST, 12'hFFF, 0, 3, 8, 0);
    add(M_ST, 12'hFFF, 8, 8, 8, 0);
    add(M_HUE, 12'h000, 8, 8, 8, 0);
    // HUE: six phases, ramp 0,2,4,6,8 in each
    add(M_HUE, 0, 8, 0, 0, 0); add(M_HUE, 0, 8, 2, 0, 0); add(M_HUE, 0, 8, 4, 0, 0);
    add(M_HUE, 0, 8, 6, 0, 0); add(M_HUE, 0, 8, 8, 0, 0);
    add(M_HUE, 0, 8, 8, 0, 1); add(M_HUE, 0, 6, 8, 0, 1); add(M_HUE, 0, 4, 8, 0, 1);
    add(M_HUE, 0, 2, 8, 0, 1); add(M_HUE, 0, 0, 8, 0, 1);
    add(M_HUE, 0, 0, 8, 0, 2); add(M_HUE, 0, 0, 8, 2, 2); add(M_HUE, 0, 0, 8, 4, 2);
    add(M_HUE, 0, 0, 8, 6, 2); add(M_HUE, 0, 0, 8, 8, 2);
    add(M_HUE, 0, 0, 8, 8, 3); add(M_HUE, 0, 0, 6, 8, 3); add(M_HUE, 0, 0, 4, 8, 3);
    add(M_HUE, 0, 0, 2, 8, 3); add(M_HUE, 0, 0, 0, 8, 3);
    add(M_HUE, 0, 0, 0, 8, 4); add(M_HUE, 0, 2, 0, 8, 4); add(M_HUE, 0, 4, 0, 8, 4);
    add(M_HUE, 0, 6, 0, 8, 4); add(M_HUE, 0, 8, 0, 8, 4);
    add(M_HUE, 0, 8, 0, 8, 5); add(M_HUE, 0, 8, 0, 6, 5); add(M_HUE, 0, 8, 0, 4, 5);
    add(M_HUE, 0, 8, 0, 2, 5); add(M_HUE, 0, 8, 0, 0, 5);
    add(M_BR, 0, 8, 0, 0, 0);
    // BREATHE triangle with one-period hold at each endpoint
    add(M_BR, 0, 0, 0, 0, 0); add(M_BR, 0, 2, 2, 2, 0); add(M_BR, 0, 4, 4, 4, 0);
    add(M_BR, 0, 6, 6, 6, 0); add(M_BR, 0, 8, 8, 8, 0); add(M_BR, 0, 8, 8, 8, 0);
    add(M_BR, 0, 6, 6, 6, 0); add(M_BR, 0, 4, 4, 4, 0); add(M_BR, 0, 2, 2, 2, 0);
    add(M_BR, 0, 0, 0, 0, 0); add(M_BR, 0, 0, 0, 0, 0); add(M_BR, 0, 2, 2, 2, 0);

    foreach (tbl[i]) begin
      run_period(0, tbl[i].m, tbl[i].sd, 1'b1, l0, l1, l2, ph, tb);
      check($sformatf("row%0d_ch0", i), l0, tbl[i].lo0);
      check($sformatf("row%0d_ch1", i), l1, tbl[i].lo1);
      check($sformatf("row%0d_ch2", i), l2, tbl[i].lo2);
      check($sformatf("row%0d_phase", i), ph, tbl[i].ph);
      check($sformatf("row%0d_tick", i), tb, 0);
    end

    // HUE into phase 1, then switch to STATIC at cnt=3
    for (int i = 0; i < 6; i++) run_period(0, M_HUE, 12'h000, 1'b1, l0, l1, l2, ph, tb);
    period_chk("hue_ph1_r0", M_HUE, 12'h000, 1'b1, 0, 8, 8, 0, 1);
    period_chk("midswitch_old", M_ST, 12'h157, 1'b1, 3, 6, 8, 0, 1);
    period_chk("midswitch_new", M_ST, 12'h157, 1'b1, 0, 7, 5, 1, 0);

    // BREATHE, drop enable at cnt=2 with ramp 6, re-enable after 3 periods
    period_chk("to_breathe", M_BR, 12'h000, 1'b1, 0, 7, 5, 1, 0);
    period_chk("br_0", M_BR, 12'h000, 1'b1, 0, 0, 0, 0, 0);
    period_chk("br_2", M_BR, 12'h000, 1'b1, 0, 2, 2, 2, 0);
    period_chk("br_4", M_BR, 12'h000, 1'b1, 0, 4, 4, 4, 0);
    period_chk("en_drop", M_BR, 12'h000, 1'b0, 2, 2, 2, 2, 0);
    for (int i = 0; i < 3; i++)
      period_chk($sformatf("disabled%0d", i), M_BR, 12'h000, 1'b0, 0, 0, 0, 0, 0);
    period_chk("reenable_6", M_BR, 12'h000, 1'b1, 0, 6, 6, 6, 0);
    period_chk("resume_8", M_BR, 12'h000, 1'b1, 0, 8, 8, 8, 0);
    period_chk("resume_hold8", M_BR, 12'h000, 1'b1, 0, 8, 8, 8, 0);

    // Async reset mid-period while outputs are low
    repeat (2) @(negedge clk);
    check("pre_rst_low", int'(pwm_out_n), 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pwm", int'(pwm_out_n), 7);
    check("async_rst_tick", int'(period_tick), 0);
    check("async_rst_phase", int'(hue_phase), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_tick(20, w);
    check("post_rst_tick_delay", w, PI);
    period_chk("post_rst_br0", M_BR, 12'h000, 1'b1, 0, 0, 0, 0, 0);
    period_chk("post_rst_br2", M_BR, 12'h000, 1'b1, 0, 2, 2, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
